// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for cache_mem_ctrl.
//   state_t    : controller FSM states (IDLE, BUSY, RESP)
//   OP_READ    : cache_op value for a read  (1'b1)
//   OP_WRITE   : cache_op value for a write (1'b0)
//   lat_cnt_w  : width of the wait-state counter for given latencies
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_READ  = 1'b1;
    localparam logic OP_WRITE = 1'b0;

    // The counter is loaded with LAT-1, so it must hold max(RD_LAT,WR_LAT)-1.
    function automatic int lat_cnt_w(input int rd_lat, input int wr_lat);
        int m;
        m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word RAM: synchronous write, asynchronous read.
// Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   addr  : word index (shared by read and write)
//   wdata : write data
//   rdata : combinational read data at addr
module mem_word_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cache_mem_ctrl.sv
// Main-memory back end for the set-associative cache. Serves single-word
// reads and writes from an internal array with programmable wait states and
// answers every request with a one-cycle mem_ready pulse.
//   clk, rst          : clock, asynchronous active-high reset
//   cache_op          : 1 = read, 0 = write
//   cache_valid       : request valid (sampled only in IDLE)
//   mem_addr          : byte address; word index = mem_addr[DEPTH_LOG2+1:2]
//   cache_write_data  : write data
//   mem_ready         : one-cycle response strobe
//   mem_data          : read data, held until the next read response
// Optional (macro MEM_STATS_EN): rd_cnt / wr_cnt saturating response counters.
module cache_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 3,
    parameter int WR_LAT     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_op,
    input  logic              cache_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] cache_write_data,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_data
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
`endif
);

    localparam int CW = lat_cnt_w(RD_LAT, WR_LAT);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic                  op_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;

    logic [DEPTH_LOG2-1:0] addr_idx;
    logic [CW-1:0]         lat_load;
    logic                  enter_resp;
    logic                  resp_op;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;
    logic                  ram_we;
    logic                  unused_addr_bits;

    assign addr_idx         = mem_addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{mem_addr[ADDR_W-1:DEPTH_LOG2+2], mem_addr[1:0]};

    // With a latency of 1 the response edge is the accept edge itself, so the
    // array is driven from the live inputs in IDLE and from the latched
    // request otherwise.
    always_comb begin
        lat_load   = (cache_op == OP_READ) ? CW'(RD_LAT - 1) : CW'(WR_LAT - 1);
        enter_resp = 1'b0;
        if (state == IDLE && cache_valid && lat_load == '0) enter_resp = 1'b1;
        if (state == BUSY && cnt == CW'(1))                 enter_resp = 1'b1;
        resp_op    = (state == IDLE) ? cache_op         : op_q;
        ram_idx    = (state == IDLE) ? addr_idx         : idx_q;
        ram_wdata  = (state == IDLE) ? cache_write_data : wdata_q;
        ram_we     = enter_resp && (resp_op == OP_WRITE);
    end

    mem_word_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= OP_WRITE;
            idx_q     <= '0;
            wdata_q   <= '0;
            mem_ready <= 1'b0;
            mem_data  <= '0;
        end else begin
            mem_ready <= enter_resp;
            if (enter_resp && resp_op == OP_READ) mem_data <= ram_rdata;
            case (state)
                IDLE: begin
                    if (cache_valid) begin
                        op_q    <= cache_op;
                        idx_q   <= addr_idx;
                        wdata_q <= cache_write_data;
                        cnt     <= lat_load;
                        state   <= (lat_load == '0) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (state == RESP) begin
            if (op_q == OP_READ  && rd_cnt != '1) rd_cnt <= rd_cnt + 16'd1;
            if (op_q == OP_WRITE && wr_cnt != '1) wr_cnt <= wr_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_ctrl.sv
module tb_cache_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cache_op;
    logic        cache_valid;
    logic [31:0] mem_addr;
    logic [31:0] cache_write_data;
    logic        mem_ready;
    logic [31:0] mem_data;
`ifdef MEM_STATS_EN
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_mem_ctrl #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .DEPTH_LOG2 (10),
        .RD_LAT     (3),
        .WR_LAT     (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cache_op         (cache_op),
        .cache_valid      (cache_valid),
        .mem_addr         (mem_addr),
        .cache_write_data (cache_write_data),
        .mem_ready        (mem_ready),
        .mem_data         (mem_data)
`ifdef MEM_STATS_EN
        ,
        .rd_cnt           (rd_cnt),
        .wr_cnt           (wr_cnt)
`endif
    );

    // Issue one request from IDLE; returns the measured latency (edges from
    // accept to the edge raising mem_ready, 0 on timeout), mem_data in the
    // response cycle, and mem_ready one cycle later. Ends back in IDLE.
    task automatic do_req(input logic op, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rd, output logic rdy_next);
        cache_op = op;
        mem_addr = addr;
        cache_write_data = wd;
        cache_valid = 1'b1;
        @(posedge clk); #1;
        cache_valid = 1'b0;
        lat = 1;
        while (!mem_ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!mem_ready) lat = 0;
        rd = mem_data;
        @(posedge clk); #1;
        rdy_next = mem_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cache_valid = 1'b0;
        cache_op = 1'b0;
        mem_addr = '0;
        cache_write_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0", mem_ready);
        end
        checks++;
        if (mem_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00000000", mem_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic rn;
        do_req(1'b0, 32'h10, 32'h2222_0001, lat, rd, rn);
        checks++;
        if (lat != 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
        checks++;
        if (rn !== 1'b0) begin failures++; $display("FAIL wr_pulse_width got=%b exp=0", rn); end
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL wr_keeps_data got=%h exp=00000000", rd); end
        do_req(1'b1, 32'h10, 32'h0, lat, rd, rn);
        checks++;
        if (lat != 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
        checks++;
        if (rd !== 32'h2222_0001) begin failures++; $display("FAIL rd_data got=%h exp=22220001", rd); end
        checks++;
        if (rn !== 1'b0) begin failures++; $display("FAIL rd_pulse_width got=%b exp=0", rn); end
    endtask

    task automatic test_alias();
        int lat; logic [31:0] rd; logic rn;
        do_req(1'b0, 32'h1020, 32'h1010_1010, lat, rd, rn);
        do_req(1'b1, 32'h0020, 32'h0, lat, rd, rn);
        checks++;
        if (rd !== 32'h1010_1010) begin failures++; $display("FAIL alias_upper got=%h exp=10101010", rd); end
        do_req(1'b1, 32'h0023, 32'h0, lat, rd, rn);
        checks++;
        if (rd !== 32'h1010_1010) begin failures++; $display("FAIL alias_low_bits got=%h exp=10101010", rd); end
    endtask

    task automatic test_back_to_back();
        int n; int lat; logic [31:0] rd; logic rn;
        cache_op = 1'b0;
        mem_addr = 32'h100;
        cache_write_data = 32'hC0DE_0100;
        cache_valid = 1'b1;
        @(posedge clk); #1;
        n = 1;
        while (!mem_ready && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != 3) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=3", n); end
        checks++;
        if (mem_data !== 32'h1010_1010) begin failures++; $display("FAIL b2b_write_holds_data got=%h exp=10101010", mem_data); end
        // switch to refill while valid stays high
        cache_op = 1'b1;
        mem_addr = 32'h10;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!mem_ready && n < 40);
        checks++;
        if (n != 4) begin failures++; $display("FAIL b2b_gap got=%0d exp=4", n); end
        checks++;
        if (mem_data !== 32'h2222_0001) begin failures++; $display("FAIL b2b_refill_data got=%h exp=22220001", mem_data); end
        cache_valid = 1'b0;
        @(posedge clk); #1;
        do_req(1'b1, 32'h100, 32'h0, lat, rd, rn);
        checks++;
        if (rd !== 32'hC0DE_0100) begin failures++; $display("FAIL b2b_writeback_data got=%h exp=c0de0100", rd); end
    endtask

    task automatic test_busy_change();
        int lat; int extra; logic [31:0] rd; logic rn;
        do_req(1'b0, 32'h4, 32'hAAAA_0004, lat, rd, rn);
        do_req(1'b0, 32'h8, 32'hBBBB_0008, lat, rd, rn);
        cache_op = 1'b1;
        mem_addr = 32'h4;
        cache_valid = 1'b1;
        @(posedge clk); #1;
        mem_addr = 32'h8;
        cache_op = 1'b0;
        cache_write_data = 32'hDEAD_BEEF;
        cache_valid = 1'b0;
        lat = 1;
        while (!mem_ready && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != 3) begin failures++; $display("FAIL busy_change_latency got=%0d exp=3", lat); end
        checks++;
        if (mem_data !== 32'hAAAA_0004) begin failures++; $display("FAIL busy_change_data got=%h exp=aaaa0004", mem_data); end
        extra = 0;
        repeat (8) begin @(posedge clk); #1; if (mem_ready) extra++; end
        checks++;
        if (extra != 0) begin failures++; $display("FAIL busy_change_extra_ready got=%0d exp=0", extra); end
        do_req(1'b1, 32'h8, 32'h0, lat, rd, rn);
        checks++;
        if (rd !== 32'hBBBB_0008) begin failures++; $display("FAIL busy_change_no_write got=%h exp=bbbb0008", rd); end
    endtask

    task automatic test_reset_mid_write();
        int lat; int seen; logic [31:0] rd; logic rn;
        do_req(1'b0, 32'h5020, 32'h1234_5020, lat, rd, rn);
        cache_op = 1'b0;
        mem_addr = 32'h5020;
        cache_write_data = 32'h5050_5050;
        cache_valid = 1'b1;
        @(posedge clk); #1;
        cache_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        checks++;
        if (mem_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_ready got=%b exp=0", mem_ready); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (mem_ready) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL rst_mid_no_resp got=%0d exp=0", seen); end
        checks++;
        if (mem_data !== 32'h0) begin failures++; $display("FAIL rst_mid_data_cleared got=%h exp=00000000", mem_data); end
        do_req(1'b1, 32'h5020, 32'h0, lat, rd, rn);
        checks++;
        if (lat != 3) begin failures++; $display("FAIL rst_mid_read_latency got=%0d exp=3", lat); end
        checks++;
        if (rd !== 32'h1234_5020) begin failures++; $display("FAIL rst_mid_prior_value got=%h exp=12345020", rd); end
    endtask

`ifdef MEM_STATS_EN
    task automatic test_stats();
        int lat; logic [31:0] rd; logic rn;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) do_req(1'b1, 32'h10, 32'h0, lat, rd, rn);
        for (int i = 0; i < 2; i++) do_req(1'b0, 32'h200, 32'h77, lat, rd, rn);
        checks++;
        if (rd_cnt !== 16'd5) begin failures++; $display("FAIL stats_rd_cnt got=%0d exp=5", rd_cnt); end
        checks++;
        if (wr_cnt !== 16'd2) begin failures++; $display("FAIL stats_wr_cnt got=%0d exp=2", wr_cnt); end
        rst = 1'b1;
        #1;
        checks++;
        if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
            failures++;
            $display("FAIL stats_reset got=%0d/%0d exp=0/0", rd_cnt, wr_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_back_to_back();
        test_busy_change();
        test_reset_mid_write();
`ifdef MEM_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
